// File: rtl/tinker_mem_responder.sv
// Byte-addressed little-endian store for the Tinker core: one outstanding 32/64-bit
// load or store at a time, fixed access latency, zero-sweep of the array after reset.
module tinker_mem_responder #(
  parameter int ADDR_W  = 19,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_size,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done
);

  localparam int ROW_W = ADDR_W - 3;
  localparam int DEPTH = 1 << ROW_W;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [ROW_W-1:0] clr_row;
  logic [3:0]       lat_cnt;

  // Eight byte lanes, lane n holds every byte whose address has addr[2:0] == n,
  // so any 8-byte window touches each lane exactly once.
  logic [7:0]       mem [8][DEPTH];

  logic [2:0]       a0;
  logic [ROW_W-1:0] base_row;
  logic [3:0]       nbytes;
  logic [2:0]       lane_idx   [8];
  logic [2:0]       byte_lane  [8];
  logic [ROW_W-1:0] lane_row   [8];
  logic [7:0]       lane_wbyte [8];
  logic [7:0]       lane_rbyte [8];
  logic [7:0]       lane_en;
  logic [63:0]      load_data;
  logic             range_err;
  logic             accept;
  logic             store_en;

  // Last touched byte computed in 33 bits so addresses near 2^32 cannot wrap into range.
  function automatic logic out_of_range(input logic [31:0] addr, input logic size);
    logic [32:0] last;
    last = {1'b0, addr} + (size ? 33'd7 : 33'd3);
    return last >= (33'd1 << ADDR_W);
  endfunction

  assign a0        = req_addr[2:0];
  assign base_row  = req_addr[ADDR_W-1:3];
  assign nbytes    = req_size ? 4'd8 : 4'd4;
  assign range_err = out_of_range(req_addr, req_size);
  assign accept    = (state == IDLE) && req_valid;
  assign store_en  = accept && req_write && !range_err;

  // Lane n carries access byte (n - a0) mod 8; lanes below a0 belong to the next row.
  always_comb begin
    load_data = '0;
    for (int l = 0; l < 8; l++) begin
      lane_idx[l]   = 3'(l) - a0;
      lane_row[l]   = base_row + ROW_W'(3'(l) < a0);
      lane_en[l]    = {1'b0, lane_idx[l]} < nbytes;
      lane_wbyte[l] = req_wdata[8*lane_idx[l] +: 8];
      lane_rbyte[l] = mem[l][lane_row[l]];
    end
    for (int i = 0; i < 8; i++) begin
      byte_lane[i] = 3'(i) + a0;
      if (4'(i) < nbytes) load_data[8*i +: 8] = lane_rbyte[byte_lane[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int l = 0; l < 8; l++) begin
        if (state == CLEAR) mem[l][clr_row] <= '0;
        else if (store_en && lane_en[l]) mem[l][lane_row[l]] <= lane_wbyte[l];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR: if (&clr_row) state_nxt = IDLE;
      IDLE:  if (req_valid) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT:  if (lat_cnt == 4'd1) state_nxt = RESP;
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // Outputs are registered from the next state so nothing is combinational from inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clr_row   <= '0;
      lat_cnt   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
      init_done <= init_done || (state_nxt != CLEAR);
      if (state == CLEAR) clr_row <= clr_row + 1'b1;
      if (accept) begin
        lat_cnt   <= LAT_INIT;
        rsp_err   <= range_err;
        rsp_rdata <= (req_write || range_err) ? 64'd0 : load_data;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_tinker_mem_responder.sv
// Directed bench for tinker_mem_responder: three small instances (latency 2, 1 and 4)
// with hand-computed expected load data, error flags and cycle counts.
module tb_tinker_mem_responder;

  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_write, req_size, rsp_ready;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_ready, rsp_valid, rsp_err, init_done;
  logic [63:0] rsp_rdata;

  logic        a1_reset, a1_req_valid, a1_req_write, a1_req_size, a1_rsp_ready;
  logic [31:0] a1_req_addr;
  logic [63:0] a1_req_wdata;
  logic        a1_req_ready, a1_rsp_valid, a1_rsp_err, a1_init_done;
  logic [63:0] a1_rsp_rdata;

  logic        a4_reset, a4_req_valid, a4_req_write, a4_req_size, a4_rsp_ready;
  logic [31:0] a4_req_addr;
  logic [63:0] a4_req_wdata;
  logic        a4_req_ready, a4_rsp_valid, a4_rsp_err, a4_init_done;
  logic [63:0] a4_rsp_rdata;

  tinker_mem_responder #(.ADDR_W(AW), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done));

  tinker_mem_responder #(.ADDR_W(AW), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(a1_reset), .req_valid(a1_req_valid), .req_ready(a1_req_ready),
    .req_write(a1_req_write), .req_size(a1_req_size), .req_addr(a1_req_addr),
    .req_wdata(a1_req_wdata), .rsp_valid(a1_rsp_valid), .rsp_ready(a1_rsp_ready),
    .rsp_rdata(a1_rsp_rdata), .rsp_err(a1_rsp_err), .init_done(a1_init_done));

  tinker_mem_responder #(.ADDR_W(AW), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .reset(a4_reset), .req_valid(a4_req_valid), .req_ready(a4_req_ready),
    .req_write(a4_req_write), .req_size(a4_req_size), .req_addr(a4_req_addr),
    .req_wdata(a4_req_wdata), .rsp_valid(a4_rsp_valid), .rsp_ready(a4_rsp_ready),
    .rsp_rdata(a4_rsp_rdata), .rsp_err(a4_rsp_err), .init_done(a4_init_done));

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the latency-2 instance; lat = cycles from accept to rsp_valid.
  task automatic do_req(input logic wr, input logic sz, input logic [31:0] addr,
                        input logic [63:0] wd, output logic [63:0] rd, output logic er,
                        output int lat);
    int w;
    w = 0;
    while (!req_ready && w < 1000) begin tick(); w++; end
    check_val("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = addr; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat, cnt, seen;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 1'b0; rsp_ready = 1'b0;
    req_addr = '0; req_wdata = '0;
    a1_reset = 1'b1; a1_req_valid = 1'b0; a1_req_write = 1'b0; a1_req_size = 1'b0;
    a1_rsp_ready = 1'b0; a1_req_addr = '0; a1_req_wdata = '0;
    a4_reset = 1'b1; a4_req_valid = 1'b0; a4_req_write = 1'b0; a4_req_size = 1'b0;
    a4_rsp_ready = 1'b0; a4_req_addr = '0; a4_req_wdata = '0;
    tick();
    check_val("rst_req_ready", 64'(req_ready), 64'd0);
    check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_val("rst_rsp_rdata", rsp_rdata, 64'd0);
    check_val("rst_rsp_err", 64'(rsp_err), 64'd0);
    check_val("rst_init_done", 64'(init_done), 64'd0);
    reset = 1'b0; a1_reset = 1'b0; a4_reset = 1'b0;

    cnt = 0;
    while (!init_done && cnt < 600) begin tick(); cnt++; end
    check_val("sweep_cycles", 64'(cnt), 64'd512);
    check_val("sweep_req_ready", 64'(req_ready), 64'd1);

    do_req(1'b0, 1'b1, 32'hFF8, 64'd0, rd, er, lat);
    check_val("load_ff8_after_sweep", rd, 64'd0);

    do_req(1'b1, 1'b1, 32'h100, 64'h0123456789ABCDEF, rd, er, lat);
    check_val("store_lat", 64'(lat), 64'd2);
    check_val("store_rdata", rd, 64'd0);
    check_val("store_err", 64'(er), 64'd0);
    do_req(1'b0, 1'b1, 32'h100, 64'd0, rd, er, lat);
    check_val("load64_100", rd, 64'h0123456789ABCDEF);
    check_val("load_lat", 64'(lat), 64'd2);
    do_req(1'b0, 1'b0, 32'h104, 64'd0, rd, er, lat);
    check_val("load32_104", rd, 64'h0000000001234567);

    do_req(1'b1, 1'b1, 32'h203, 64'h1122334455667788, rd, er, lat);
    do_req(1'b1, 1'b0, 32'h205, 64'hFFFFFFFFAABBCCDD, rd, er, lat);
    do_req(1'b0, 1'b1, 32'h203, 64'd0, rd, er, lat);
    check_val("load64_203_merged", rd, 64'h1122AABBCCDD7788);
    do_req(1'b0, 1'b0, 32'h208, 64'd0, rd, er, lat);
    check_val("load32_208_20b_untouched", rd, 64'h00000000001122AA);

    do_req(1'b1, 1'b1, 32'hFFC, 64'hFFFFFFFFFFFFFFFF, rd, er, lat);
    check_val("oor_store_err", 64'(er), 64'd1);
    check_val("oor_store_rdata", rd, 64'd0);
    do_req(1'b0, 1'b1, 32'hFF8, 64'd0, rd, er, lat);
    check_val("oor_no_write", rd, 64'd0);
    check_val("load64_ff8_err", 64'(er), 64'd0);
    do_req(1'b1, 1'b0, 32'hFFC, 64'h00000000DEADBEEF, rd, er, lat);
    check_val("store32_ffc_err", 64'(er), 64'd0);
    do_req(1'b0, 1'b0, 32'hFFC, 64'd0, rd, er, lat);
    check_val("load32_ffc_err", 64'(er), 64'd0);
    check_val("load32_ffc", rd, 64'h00000000DEADBEEF);
    do_req(1'b0, 1'b1, 32'hFFFFFFFC, 64'd0, rd, er, lat);
    check_val("load_wrap_err", 64'(er), 64'd1);
    check_val("load_wrap_rdata", rd, 64'd0);

    // Backpressure with a pending load; write pulses in the window must be ignored.
    req_valid = 1'b1; req_write = 1'b0; req_size = 1'b1; req_addr = 32'h100;
    tick();
    req_valid = 1'b0;
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin tick(); cnt++; end
    for (int k = 0; k < 5; k++) begin
      check_val("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check_val("bp_rsp_rdata", rsp_rdata, 64'h0123456789ABCDEF);
      check_val("bp_req_ready", 64'(req_ready), 64'd0);
      req_valid = (k % 2 == 0); req_write = 1'b1; req_wdata = 64'hFFFFFFFFFFFFFFFF;
      tick();
    end
    req_valid = 1'b0; req_write = 1'b0;
    check_val("bp_rsp_valid_end", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_val("bp_req_ready_after", 64'(req_ready), 64'd1);
    do_req(1'b0, 1'b1, 32'h100, 64'd0, rd, er, lat);
    check_val("bp_no_accept", rd, 64'h0123456789ABCDEF);

    // Latency 1: response visible right after the accept edge.
    a1_req_valid = 1'b1; a1_req_write = 1'b1; a1_req_size = 1'b0;
    a1_req_addr = 32'h40; a1_req_wdata = 64'h00000000CAFEF00D;
    tick();
    a1_req_valid = 1'b0;
    check_val("l1_store_valid", 64'(a1_rsp_valid), 64'd1);
    a1_rsp_ready = 1'b1;
    tick();
    a1_rsp_ready = 1'b0;
    a1_req_valid = 1'b1; a1_req_write = 1'b0; a1_req_size = 1'b1; a1_req_addr = 32'h3E;
    tick();
    a1_req_valid = 1'b0;
    check_val("l1_load_valid", 64'(a1_rsp_valid), 64'd1);
    check_val("l1_load_rdata", a1_rsp_rdata, 64'h0000CAFEF00D0000);
    a1_rsp_ready = 1'b1;
    tick();
    a1_rsp_ready = 1'b0;

    // Latency 4, then reset while WAIT holds a pending load.
    a4_req_valid = 1'b1; a4_req_write = 1'b1; a4_req_size = 1'b1;
    a4_req_addr = 32'h10; a4_req_wdata = 64'h5A5A5A5A5A5A5A5A;
    tick();
    a4_req_valid = 1'b0;
    cnt = 1;
    while (!a4_rsp_valid && cnt < 20) begin tick(); cnt++; end
    check_val("l4_lat", 64'(cnt), 64'd4);
    a4_rsp_ready = 1'b1;
    tick();
    a4_rsp_ready = 1'b0;
    a4_req_valid = 1'b1; a4_req_write = 1'b0;
    tick();
    a4_req_valid = 1'b0;
    a4_reset = 1'b1;
    tick();
    a4_reset = 1'b0;
    check_val("l4_rst_rsp_valid", 64'(a4_rsp_valid), 64'd0);
    check_val("l4_rst_init_done", 64'(a4_init_done), 64'd0);
    check_val("l4_rst_req_ready", 64'(a4_req_ready), 64'd0);
    seen = 0;
    cnt = 0;
    while (!a4_init_done && cnt < 600) begin
      if (a4_rsp_valid) seen = 1;
      tick();
      cnt++;
    end
    check_val("l4_no_rsp_during_sweep", 64'(seen), 64'd0);
    check_val("l4_resweep_cycles", 64'(cnt), 64'd512);
    a4_req_valid = 1'b1;
    tick();
    a4_req_valid = 1'b0;
    cnt = 1;
    while (!a4_rsp_valid && cnt < 20) begin tick(); cnt++; end
    check_val("l4_cleared_load", a4_rsp_rdata, 64'd0);
    a4_rsp_ready = 1'b1;
    tick();
    a4_rsp_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
